// File: rtl/fpu_ss_pkg.sv
// Shared types for the fpu_ss X-interface and its multi-core issue arbiter.
// Core index type and pointer-width helper live here as well.
package fpu_ss_pkg;

    localparam int NB_CORES_MAX = 16;

    typedef logic [3:0] core_idx_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [1:0]  mode;
        logic [3:0]  id;
    } x_issue_req_t;

    typedef struct packed {
        logic accept;
        logic writeback;
        logic loadstore;
    } x_issue_resp_t;

    typedef struct packed {
        logic [3:0] id;
        logic       commit_kill;
    } x_commit_t;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fpu_ss_commit_fifo.sv
// Per-core commit FIFO with fall-through head: a push into an empty FIFO
// is visible on data_o in the same cycle so the drain can take it directly.
module fpu_ss_commit_fifo
    import fpu_ss_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      push_i,
    input  x_commit_t data_i,
    input  logic      pop_i,
    output x_commit_t data_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int AW = $clog2(DEPTH);

    x_commit_t     mem_q [DEPTH];
    logic [AW-1:0] rd_q;
    logic [AW-1:0] wr_q;
    logic [AW:0]   cnt_q;
    logic          bypass;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign data_o  = empty_o ? data_i : mem_q[rd_q];
    assign bypass  = empty_o && push_i && pop_i;
    assign do_push = push_i && !bypass && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    // Pointer and occupancy update
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage write; contents need no reset
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

    // A core must never overrun its commit FIFO
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(push_i && full_o && !pop_i))
            else $warning("commit push into full fifo dropped");
        end
    end

endmodule

// File: rtl/fpu_ss_issue_arbiter.sv
// Shares one fpu_ss among NB_CORES cores: round-robin issue with lock
// until handshake, and round-robin serialisation of per-core commits.
module fpu_ss_issue_arbiter
    import fpu_ss_pkg::*;
#(
    parameter int NB_CORES     = 8,
    parameter int COMMIT_DEPTH = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NB_CORES-1:0]          core_issue_valid_i,
    output logic [NB_CORES-1:0]          core_issue_ready_o,
    input  x_issue_req_t [NB_CORES-1:0]  core_issue_req_i,
    output x_issue_resp_t [NB_CORES-1:0] core_issue_resp_o,
    input  logic [NB_CORES-1:0]          core_commit_valid_i,
    input  x_commit_t [NB_CORES-1:0]     core_commit_i,
    output logic [NB_CORES-1:0]          core_commit_full_o,
    output logic                         x_issue_valid_o,
    input  logic                         x_issue_ready_i,
    output x_issue_req_t                 x_issue_req_o,
    input  x_issue_resp_t                x_issue_resp_i,
    output logic [31:0]                  core_id_o,
    output logic                         x_commit_valid_o,
    output x_commit_t                    x_commit_o,
    output logic [31:0]                  commit_core_id_o
);

    localparam int PTR_W = ptr_width(NB_CORES);

    typedef logic [PTR_W-1:0] ptr_t;

    // First set bit at or after ptr, wrapping; returns ptr when none set
    function automatic ptr_t rr_pick(
        input logic [NB_CORES-1:0] req,
        input ptr_t                ptr
    );
        ptr_t sel;
        ptr_t idx;
        logic hit;
        int   k;
        sel = ptr;
        hit = 1'b0;
        for (int i = 0; i < NB_CORES; i++) begin
            k   = (int'(ptr) + i) % NB_CORES;
            idx = PTR_W'(k);
            if (!hit && req[idx]) begin
                sel = idx;
                hit = 1'b1;
            end
        end
        return sel;
    endfunction

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (int'(p) == NB_CORES - 1) ? '0 : p + PTR_W'(1);
    endfunction

    ptr_t rr_q, rr_d;
    ptr_t lock_idx_q, lock_idx_d;
    logic lock_q, lock_d;
    ptr_t grant;

    assign grant = lock_q ? lock_idx_q
                          : rr_pick(core_issue_valid_i, rr_q);

    assign x_issue_valid_o = core_issue_valid_i[grant];
    assign x_issue_req_o   = core_issue_req_i[grant];
    assign core_id_o       = 32'(grant);

    // Route ready/response back to the granted core only
    always_comb begin
        core_issue_ready_o = '0;
        core_issue_resp_o  = '0;
        if (x_issue_valid_o) begin
            core_issue_ready_o[grant] = x_issue_ready_i;
            core_issue_resp_o[grant]  = x_issue_resp_i;
        end
    end

    // Issue arbitration next state: hold grant until handshake
    always_comb begin
        rr_d       = rr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (lock_q) begin
            if (!x_issue_valid_o) begin
                lock_d = 1'b0;
            end else if (x_issue_ready_i) begin
                lock_d = 1'b0;
                rr_d   = ptr_inc(lock_idx_q);
            end
        end else if (x_issue_valid_o) begin
            if (x_issue_ready_i) begin
                rr_d = ptr_inc(grant);
            end else begin
                lock_d     = 1'b1;
                lock_idx_d = grant;
            end
        end
    end

    // Issue arbitration state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            rr_q       <= rr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    // A locked core must keep valid up until its handshake
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(lock_q && !x_issue_valid_o))
            else $warning("locked issuer dropped valid before handshake");
        end
    end

    logic [NB_CORES-1:0]      empty;
    logic [NB_CORES-1:0]      avail;
    logic [NB_CORES-1:0]      pop;
    x_commit_t [NB_CORES-1:0] head;
    ptr_t                     crr_q;
    ptr_t                     csel;
    logic                     x_commit_valid_q;
    x_commit_t                x_commit_q;
    logic [31:0]              commit_core_id_q;

    for (genvar i = 0; i < NB_CORES; i++) begin : g_fifo
        fpu_ss_commit_fifo #(
            .DEPTH (COMMIT_DEPTH)
        ) u_fifo (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .push_i  (core_commit_valid_i[i]),
            .data_i  (core_commit_i[i]),
            .pop_i   (pop[i]),
            .data_o  (head[i]),
            .full_o  (core_commit_full_o[i]),
            .empty_o (empty[i])
        );
    end

    assign avail = ~empty | core_commit_valid_i;
    assign csel  = rr_pick(avail, crr_q);

    // Pop exactly the FIFO chosen by the commit round-robin
    always_comb begin
        pop = '0;
        if (|avail) pop[csel] = 1'b1;
    end

    // Register the drained head onto the single commit port
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            crr_q            <= '0;
            x_commit_valid_q <= 1'b0;
            x_commit_q       <= '0;
            commit_core_id_q <= '0;
        end else if (|avail) begin
            crr_q            <= ptr_inc(csel);
            x_commit_valid_q <= 1'b1;
            x_commit_q       <= head[csel];
            commit_core_id_q <= 32'(csel);
        end else begin
            x_commit_valid_q <= 1'b0;
        end
    end

    assign x_commit_valid_o = x_commit_valid_q;
    assign x_commit_o       = x_commit_q;
    assign commit_core_id_o = commit_core_id_q;

endmodule

// File: tb/tb_fpu_ss_issue_arbiter.sv
// Bench for fpu_ss_issue_arbiter: queued expected grants/commits checked
// by a negedge monitor, plus direct checks of combinational outputs.
module tb_fpu_ss_issue_arbiter;
    import fpu_ss_pkg::*;

    localparam int N = 8;
    localparam int D = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N-1:0]          iv;
    logic [N-1:0]          irdy;
    x_issue_req_t [N-1:0]  ireq;
    x_issue_resp_t [N-1:0] iresp;
    logic [N-1:0]          cv;
    x_commit_t [N-1:0]     cpl;
    logic [N-1:0]          cfull;
    logic                  xv;
    logic                  xr;
    x_issue_req_t          xreq;
    x_issue_resp_t         xresp;
    logic [31:0]           cid;
    logic                  xcv;
    x_commit_t             xc;
    logic [31:0]           ccid;

    fpu_ss_issue_arbiter #(
        .NB_CORES     (N),
        .COMMIT_DEPTH (D)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .core_issue_valid_i  (iv),
        .core_issue_ready_o  (irdy),
        .core_issue_req_i    (ireq),
        .core_issue_resp_o   (iresp),
        .core_commit_valid_i (cv),
        .core_commit_i       (cpl),
        .core_commit_full_o  (cfull),
        .x_issue_valid_o     (xv),
        .x_issue_ready_i     (xr),
        .x_issue_req_o       (xreq),
        .x_issue_resp_i      (xresp),
        .core_id_o           (cid),
        .x_commit_valid_o    (xcv),
        .x_commit_o          (xc),
        .commit_core_id_o    (ccid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         core;
        logic [3:0] id;
    } cmt_exp_t;

    int       n_cmp = 0;
    int       n_bad = 0;
    logic     mon_en = 1'b0;
    int       iss_q[$];
    cmt_exp_t cmt_q[$];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmt(input int core, input logic [3:0] id);
        cmt_exp_t e;
        e.core = core;
        e.id   = id;
        cmt_q.push_back(e);
    endtask

    // Monitor: every issue handshake and every commit beat must match
    // the oldest queued expectation
    always @(negedge clk) begin
        if (mon_en) begin
            if (xv && xr) begin
                if (iss_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL issue_unexpected: core %0d", cid);
                end else begin
                    int g;
                    g = iss_q.pop_front();
                    check("issue_core", 64'(cid), 64'(g));
                    check("issue_instr", 64'(xreq.instr),
                          64'(32'hC0DE_0000 + g));
                end
            end
            if (xcv) begin
                if (cmt_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL commit_unexpected: core %0d id %0d",
                             ccid, xc.id);
                end else begin
                    cmt_exp_t e;
                    e = cmt_q.pop_front();
                    check("commit_core", 64'(ccid), 64'(e.core));
                    check("commit_id", 64'(xc.id), 64'(e.id));
                end
            end
        end
    end

    initial begin
        rst   = 1'b1;
        iv    = '0;
        xr    = 1'b0;
        cv    = '0;
        cpl   = '0;
        xresp = '{accept: 1'b1, writeback: 1'b0, loadstore: 1'b1};
        for (int i = 0; i < N; i++) begin
            ireq[i].instr = 32'hC0DE_0000 + i;
            ireq[i].mode  = 2'd0;
            ireq[i].id    = 4'(i);
        end
        repeat (3) tick();
        rst    = 1'b0;
        mon_en = 1'b1;
        #1;

        // Reset state
        check("rst_xv", 64'(xv), 64'd0);
        check("rst_ready", 64'(irdy), 64'd0);
        check("rst_core_id", 64'(cid), 64'd0);
        check("rst_xcv", 64'(xcv), 64'd0);
        check("rst_xc", 64'(xc), 64'd0);
        check("rst_ccid", 64'(ccid), 64'd0);
        check("rst_full", 64'(cfull), 64'd0);

        // Single requester, same-cycle grant
        iv = 8'h08;
        xr = 1'b1;
        iss_q.push_back(3);
        #1;
        check("single_core_id", 64'(cid), 64'd3);
        check("single_ready", 64'(irdy), 64'h08);
        check("single_resp3", 64'(iresp[3]), 64'(xresp));
        check("single_resp2", 64'(iresp[2]), 64'd0);
        tick();

        // All valid: rotation resumes at 4
        iv = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            iss_q.push_back((4 + k) % N);
            tick();
        end
        iv = '0;
        xr = 1'b0;
        tick();

        // Lock on core 2 while ready stays low
        iv = 8'h04;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("lock_hold", 64'(cid), 64'd2);
            tick();
        end
        iv = 8'h24;
        #1;
        check("lock_vs_5_id", 64'(cid), 64'd2);
        check("lock_vs_5_xv", 64'(xv), 64'd1);
        check("lock_vs_5_rdy", 64'(irdy), 64'd0);
        tick();
        xr = 1'b1;
        iss_q.push_back(2);
        #1;
        check("lock_release", 64'(irdy), 64'h04);
        tick();
        iv = 8'h20;
        iss_q.push_back(5);
        #1;
        check("after_lock", 64'(cid), 64'd5);
        tick();
        iv = '0;
        xr = 1'b0;
        tick();

        // Two commits in one cycle: core 1 first, core 6 next
        cv        = 8'h42;
        cpl[1].id = 4'd7;
        cpl[6].id = 4'd9;
        push_cmt(1, 4'd7);
        push_cmt(6, 4'd9);
        tick();
        cv = '0;
        check("cmt_lat1_v", 64'(xcv), 64'd1);
        check("cmt_lat1_core", 64'(ccid), 64'd1);
        tick();
        check("cmt_lat2_core", 64'(ccid), 64'd6);
        tick();

        // Core 0 overruns its FIFO while others hold the drain
        cv        = 8'h01;
        cpl[0].id = 4'd11;
        push_cmt(0, 4'd11);
        tick();
        cv        = 8'hFF;
        cpl[0].id = 4'd12;
        for (int i = 1; i < N; i++) cpl[i].id = 4'(i);
        push_cmt(1, 4'd1);
        tick();
        cv        = 8'h01;
        cpl[0].id = 4'd13;
        push_cmt(2, 4'd2);
        #1;
        check("ovf_not_full", 64'(cfull), 64'd0);
        tick();
        cpl[0].id = 4'd14;
        push_cmt(3, 4'd3);
        #1;
        check("ovf_full", 64'(cfull), 64'h01);
        tick();
        cv = '0;
        for (int i = 4; i < N; i++) push_cmt(i, 4'(i));
        push_cmt(0, 4'd12);
        push_cmt(0, 4'd13);
        repeat (10) tick();

        // Reset while locked on core 4 with a commit in flight
        iv        = 8'h10;
        xr        = 1'b0;
        cv        = 8'h04;
        cpl[2].id = 4'd5;
        push_cmt(2, 4'd5);
        #1;
        check("rl_grant", 64'(cid), 64'd4);
        tick();
        cv  = '0;
        iv  = 8'h52;
        rst = 1'b1;
        #1;
        check("rl_locked", 64'(cid), 64'd4);
        check("rl_xcv_pre", 64'(xcv), 64'd1);
        tick();
        rst = 1'b0;
        xr  = 1'b1;
        iss_q.push_back(1);
        #1;
        check("rl_xcv", 64'(xcv), 64'd0);
        check("rl_ccid", 64'(ccid), 64'd0);
        check("rl_regrant", 64'(cid), 64'd1);
        tick();
        iv = '0;
        xr = 1'b0;
        repeat (4) tick();

        check("iss_q_drained", 64'(iss_q.size()), 64'd0);
        check("cmt_q_drained", 64'(cmt_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
